// File: rtl/cache_responder.sv
// cache_responder: responder end of the 4-phase cache request/valid protocol.
// Direct-mapped, write-back, write-allocate cache with one word per line.
// Misses and dirty evictions are served through a req/ack backing-memory port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for request; latches operation/addr/wdata
// LOOKUP    | tag compare, HIT_LAT cycles, then decide the path
// WRITEBACK | dirty victim is written to memory
// FILL      | line is read from memory (READ miss only)
// RESPOND   | valid high until the master drops request
module cache_responder #(
    parameter int WORD_W  = 8,
    parameter int ADDR_W  = 32,
    parameter int LINES   = 16,
    parameter int HIT_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        operation,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              request,
    output logic              valid,
    output logic [WORD_W-1:0] rdata,
    output logic              evict,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int CNT_W = (HIT_LAT > 1) ? $clog2(HIT_LAT) : 1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic              evict_pend;
    logic [CNT_W-1:0]  lkp_cnt;

    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [WORD_W-1:0] data_arr [LINES];
    logic [LINES-1:0]  line_vld;
    logic [LINES-1:0]  line_dirty;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  lat_tag;
    logic              hit;
    logic              vic_dirty;
    logic              mem_done;
    logic              lkp_done;

    assign idx       = lat_addr[IDX_W-1:0];
    assign lat_tag   = lat_addr[ADDR_W-1:IDX_W];
    assign hit       = line_vld[idx] && (tag_arr[idx] == lat_tag);
    assign vic_dirty = line_vld[idx] && line_dirty[idx];
    // an ack only counts while a memory request is actually outstanding
    assign mem_done  = mem_req && mem_ack;
    assign lkp_done  = (lkp_cnt == '0);

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (request) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lkp_done) begin
                    case (lat_op)
                        OP_READ:  state_nxt = hit ? S_RESPOND : (vic_dirty ? S_WRITEBACK : S_FILL);
                        OP_WRITE: state_nxt = (!hit && vic_dirty) ? S_WRITEBACK : S_RESPOND;
                        OP_INV:   state_nxt = (hit && line_dirty[idx]) ? S_WRITEBACK : S_RESPOND;
                        default:  state_nxt = S_RESPOND;
                    endcase
                end
            end
            S_WRITEBACK: begin
                if (mem_done) state_nxt = (lat_op == OP_READ) ? S_FILL : S_RESPOND;
            end
            S_FILL: begin
                if (mem_done) state_nxt = S_RESPOND;
            end
            S_RESPOND: begin
                if (!request) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // datapath, cache arrays and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            line_vld   <= '0;
            line_dirty <= '0;
            lat_op     <= OP_NOP;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            evict_pend <= 1'b0;
            lkp_cnt    <= '0;
            valid      <= 1'b0;
            evict      <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            valid <= (state_nxt == S_RESPOND);
            evict <= (state_nxt == S_RESPOND) && (evict_pend || state == S_WRITEBACK);
            case (state)
                S_IDLE: begin
                    if (request) begin
                        lat_op     <= operation;
                        lat_addr   <= addr;
                        lat_wdata  <= wdata;
                        evict_pend <= 1'b0;
                        lkp_cnt    <= CNT_W'(HIT_LAT - 1);
                    end
                end
                S_LOOKUP: begin
                    if (!lkp_done) begin
                        lkp_cnt <= lkp_cnt - 1'b1;
                    end else begin
                        case (lat_op)
                            OP_READ: begin
                                if (hit) rdata <= data_arr[idx];
                            end
                            OP_WRITE: begin
                                // hit updates in place; clean miss allocates without a fill
                                if (hit || !vic_dirty) begin
                                    tag_arr[idx]    <= lat_tag;
                                    data_arr[idx]   <= lat_wdata;
                                    line_vld[idx]   <= 1'b1;
                                    line_dirty[idx] <= 1'b1;
                                end
                            end
                            OP_INV: begin
                                if (hit && !line_dirty[idx]) line_vld[idx] <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITEBACK: begin
                    evict_pend <= 1'b1;
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {tag_arr[idx], idx};
                        mem_wdata <= data_arr[idx];
                    end else if (mem_ack) begin
                        mem_req         <= 1'b0;
                        line_dirty[idx] <= 1'b0;
                        if (lat_op == OP_WRITE) begin
                            tag_arr[idx]    <= lat_tag;
                            data_arr[idx]   <= lat_wdata;
                            line_vld[idx]   <= 1'b1;
                            line_dirty[idx] <= 1'b1;
                        end else if (lat_op == OP_INV) begin
                            line_vld[idx] <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    // mem_req is low for a cycle after a writeback, so the address
                    // change from victim to fill never happens under a live request
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= lat_addr;
                    end else if (mem_ack) begin
                        mem_req         <= 1'b0;
                        tag_arr[idx]    <= lat_tag;
                        data_arr[idx]   <= mem_rdata;
                        line_vld[idx]   <= 1'b1;
                        line_dirty[idx] <= 1'b0;
                        rdata           <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
